pipeline_hazard_ctrl: RTL and testbench

Sequencing controller for the five-stage core pipeline (decode, readreg, execute, memwrt, regwrt). Each cycle it decides whether the fetch PC and S1 advance, which stage registers are cleared (`rst_p`), and when the PC is redirected to a resolved delayed branch. It covers load-use stalls, branch flushes and an external halt handshake, and it keeps saturating stall and flush counters. It sits beside the pipeline assembly and drives its `update_1in` and `rst_p` inputs plus the fetch PC controls.

---
 rtl/pipeline_hazard_ctrl.sv | 132 +++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencing: load-use stalls, branch flush, halt handshake.
// Drives S1 update, per-stage clears and fetch PC hold/redirect.
module pipeline_hazard_ctrl #(
  parameter int PC_W  = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       num_Rm_1,
  input  logic [2:0]       num_Rn_1,
  input  logic [2:0]       num_Rd_1,
  input  logic [2:0]       used_RmRnRd_1,
  input  logic             write_2,
  input  logic [2:0]       writenum_2,
  input  logic             loads_2,
  input  logic             write_3,
  input  logic [2:0]       writenum_3,
  input  logic             loads_3,
  input  logic             do_delayed_B_4,
  input  logic [15:0]      delayed_B_4,
  input  logic             halt_req,
  output logic             halt_ack,
  output logic             update_1in,
  output logic [4:1]       rst_p,
  output logic             pc_hold,
  output logic             pc_load,
  output logic [PC_W-1:0]  pc_target,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic [1:0] {
    RUN,
    BRFLUSH,
    HALTED
  } state_t;

  state_t state, nxt;
  logic   hit_2, hit_3, haz;
  logic   inc_st, inc_fl;
  logic   unused_hi;

  assign unused_hi = ^delayed_B_4[15:PC_W];

  assign hit_2 =
    (used_RmRnRd_1[2] && num_Rm_1 == writenum_2) ||
    (used_RmRnRd_1[1] && num_Rn_1 == writenum_2) ||
    (used_RmRnRd_1[0] && num_Rd_1 == writenum_2);

  assign hit_3 =
    (used_RmRnRd_1[2] && num_Rm_1 == writenum_3) ||
    (used_RmRnRd_1[1] && num_Rn_1 == writenum_3) ||
    (used_RmRnRd_1[0] && num_Rd_1 == writenum_3);

  // ALU results are forwarded, so only loads stall
  assign haz = (loads_2 && write_2 && hit_2) ||
               (loads_3 && write_3 && hit_3);

  always_comb begin
    nxt        = state;
    update_1in = 1'b1;
    rst_p      = 4'b0000;
    pc_hold    = 1'b0;
    pc_load    = 1'b0;
    pc_target  = '0;
    halt_ack   = 1'b0;
    inc_st     = 1'b0;
    inc_fl     = 1'b0;
    if (!rst) begin
      update_1in = 1'b0;
      rst_p      = 4'b1111;
      pc_hold    = 1'b1;
    end else begin
      unique case (state)
        RUN: begin
          if (do_delayed_B_4) begin
            pc_load   = 1'b1;
            pc_target = delayed_B_4[PC_W-1:0];
            rst_p     = 4'b0111;
            nxt       = BRFLUSH;
            inc_fl    = 1'b1;
          end else if (haz) begin
            update_1in = 1'b0;
            pc_hold    = 1'b1;
            rst_p      = 4'b0010;
            inc_st     = 1'b1;
          end else if (halt_req) begin
            update_1in = 1'b0;
            pc_hold    = 1'b1;
            rst_p      = 4'b0010;
            nxt        = HALTED;
          end
        end
        // wrong-path word still on IR_in is dropped
        BRFLUSH: begin
          rst_p = 4'b0001;
          nxt   = RUN;
        end
        HALTED: begin
          halt_ack = 1'b1;
          if (do_delayed_B_4) begin
            pc_load   = 1'b1;
            pc_target = delayed_B_4[PC_W-1:0];
            rst_p     = 4'b0111;
            inc_fl    = 1'b1;
          end else begin
            update_1in = 1'b0;
            pc_hold    = 1'b1;
            rst_p      = 4'b0010;
            if (!halt_req) nxt = RUN;
          end
        end
        default: nxt = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= RUN;
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      state <= nxt;
      if (inc_st && stall_cycles != '1)
        stall_cycles <= stall_cycles + 1'b1;
      if (inc_fl && flush_count != '1)
        flush_count <= flush_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with an expected-output queue.
// Counters are narrowed so saturation is reachable quickly.
module tb_pipeline_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  num_Rm_1, num_Rn_1, num_Rd_1, used_RmRnRd_1;
  logic        write_2, loads_2, write_3, loads_3;
  logic [2:0]  writenum_2, writenum_3;
  logic        do_delayed_B_4;
  logic [15:0] delayed_B_4;
  logic        halt_req;
  logic        halt_ack, update_1in, pc_hold, pc_load;
  logic [4:1]  rst_p;
  logic [7:0]  pc_target;
  logic [3:0]  stall_cycles, flush_count;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.PC_W(8), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .num_Rm_1(num_Rm_1), .num_Rn_1(num_Rn_1), .num_Rd_1(num_Rd_1),
    .used_RmRnRd_1(used_RmRnRd_1),
    .write_2(write_2), .writenum_2(writenum_2), .loads_2(loads_2),
    .write_3(write_3), .writenum_3(writenum_3), .loads_3(loads_3),
    .do_delayed_B_4(do_delayed_B_4), .delayed_B_4(delayed_B_4),
    .halt_req(halt_req), .halt_ack(halt_ack),
    .update_1in(update_1in), .rst_p(rst_p),
    .pc_hold(pc_hold), .pc_load(pc_load), .pc_target(pc_target),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  typedef struct {
    string      tag;
    logic       upd;
    logic [3:0] rp;
    logic       hold;
    logic       load;
    logic [7:0] tgt;
    logic       ack;
    logic [3:0] st;
    logic [3:0] fl;
  } exp_t;

  exp_t sbq[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(string tag, string f, logic [15:0] obs,
                     logic [15:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s.%s observed=%0h expected=%0h", tag, f, obs, expv);
    end
  endtask

  task automatic compare_out();
    exp_t e;
    checks++;
    assert (sbq.size() > 0) else begin
      failures++;
      $error("FAIL scoreboard observed=empty expected=entry");
      return;
    end
    e = sbq.pop_front();
    chk(e.tag, "update_1in", 16'(update_1in), 16'(e.upd));
    chk(e.tag, "rst_p", 16'(rst_p), 16'(e.rp));
    chk(e.tag, "pc_hold", 16'(pc_hold), 16'(e.hold));
    chk(e.tag, "pc_load", 16'(pc_load), 16'(e.load));
    chk(e.tag, "pc_target", 16'(pc_target), 16'(e.tgt));
    chk(e.tag, "halt_ack", 16'(halt_ack), 16'(e.ack));
    chk(e.tag, "stall_cycles", 16'(stall_cycles), 16'(e.st));
    chk(e.tag, "flush_count", 16'(flush_count), 16'(e.fl));
  endtask

  task automatic expect_out(string tag, logic upd, logic [3:0] rp,
                            logic hold, logic load, logic [7:0] tgt,
                            logic ack, logic [3:0] st, logic [3:0] fl);
    exp_t e;
    e = '{tag, upd, rp, hold, load, tgt, ack, st, fl};
    sbq.push_back(e);
  endtask

  task automatic step(string tag, logic upd, logic [3:0] rp,
                      logic hold, logic load, logic [7:0] tgt,
                      logic ack, logic [3:0] st, logic [3:0] fl);
    expect_out(tag, upd, rp, hold, load, tgt, ack, st, fl);
    @(negedge clk);
    compare_out();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    num_Rm_1 = 3'd0; num_Rn_1 = 3'd0; num_Rd_1 = 3'd0;
    used_RmRnRd_1 = 3'b000;
    write_2 = 1'b0; writenum_2 = 3'd0; loads_2 = 1'b0;
    write_3 = 1'b0; writenum_3 = 3'd0; loads_3 = 1'b0;
    do_delayed_B_4 = 1'b0; delayed_B_4 = 16'h0000;
    halt_req = 1'b0;
  endtask

  task automatic s1_reads(logic [2:0] rm, logic [2:0] rn,
                          logic [2:0] rd, logic [2:0] used);
    num_Rm_1 = rm; num_Rn_1 = rn; num_Rd_1 = rd;
    used_RmRnRd_1 = used;
  endtask

  task automatic ld2(logic [2:0] n);
    loads_2 = 1'b1; write_2 = 1'b1; writenum_2 = n;
  endtask

  task automatic ld3(logic [2:0] n);
    loads_3 = 1'b1; write_3 = 1'b1; writenum_3 = n;
  endtask

  task automatic branch(logic [15:0] t);
    do_delayed_B_4 = 1'b1; delayed_B_4 = t;
  endtask

  initial begin
    rst = 1'b0;
    clr_in();
    #2;
    expect_out("reset", 0, 4'b1111, 1, 0, 8'h00, 0, 0, 0);
    compare_out();
    @(posedge clk);
    #1;
    rst = 1'b1;

    step("idle", 1, 4'b0000, 0, 0, 8'h00, 0, 0, 0);

    // load r3 in S2, S1 reads Rm=r3: two stall cycles
    clr_in(); ld2(3'd3); s1_reads(3'd3, 3'd0, 3'd0, 3'b100);
    step("ld_s2", 0, 4'b0010, 1, 0, 8'h00, 0, 0, 0);
    clr_in(); ld3(3'd3); s1_reads(3'd3, 3'd0, 3'd0, 3'b100);
    step("ld_s3", 0, 4'b0010, 1, 0, 8'h00, 0, 1, 0);
    clr_in(); s1_reads(3'd3, 3'd0, 3'd0, 3'b100);
    step("after_ld", 1, 4'b0000, 0, 0, 8'h00, 0, 2, 0);

    clr_in(); write_2 = 1'b1; writenum_2 = 3'd3;
    s1_reads(3'd3, 3'd0, 3'd0, 3'b100);
    step("alu_s2", 1, 4'b0000, 0, 0, 8'h00, 0, 2, 0);

    clr_in(); ld2(3'd3); s1_reads(3'd3, 3'd1, 3'd2, 3'b011);
    step("rm_unused", 1, 4'b0000, 0, 0, 8'h00, 0, 2, 0);

    clr_in(); ld3(3'd6); s1_reads(3'd0, 3'd1, 3'd6, 3'b001);
    step("rd_hit_s3", 0, 4'b0010, 1, 0, 8'h00, 0, 2, 0);

    clr_in(); ld3(3'd6); write_3 = 1'b0;
    s1_reads(3'd0, 3'd6, 3'd0, 3'b010);
    step("s3_nowrite", 1, 4'b0000, 0, 0, 8'h00, 0, 3, 0);

    clr_in(); branch(16'h1242);
    step("br", 1, 4'b0111, 0, 1, 8'h42, 0, 3, 0);
    clr_in(); branch(16'h0011); halt_req = 1'b1;
    ld2(3'd2); s1_reads(3'd2, 3'd0, 3'd0, 3'b100);
    step("brflush", 1, 4'b0001, 0, 0, 8'h00, 0, 3, 1);
    clr_in();
    step("post_br", 1, 4'b0000, 0, 0, 8'h00, 0, 3, 1);

    clr_in(); branch(16'h00AA); ld2(3'd4);
    s1_reads(3'd0, 3'd4, 3'd0, 3'b010);
    step("br_vs_haz", 1, 4'b0111, 0, 1, 8'hAA, 0, 3, 1);
    clr_in();
    step("brflush2", 1, 4'b0001, 0, 0, 8'h00, 0, 3, 2);
    step("post_br2", 1, 4'b0000, 0, 0, 8'h00, 0, 3, 2);

    // five-cycle halt request
    clr_in(); halt_req = 1'b1;
    step("halt_c0", 0, 4'b0010, 1, 0, 8'h00, 0, 3, 2);
    for (int i = 1; i <= 4; i++)
      step($sformatf("halt_c%0d", i), 0, 4'b0010, 1, 0, 8'h00, 1, 3, 2);
    halt_req = 1'b0;
    step("halt_c5", 0, 4'b0010, 1, 0, 8'h00, 1, 3, 2);
    step("halt_exit", 1, 4'b0000, 0, 0, 8'h00, 0, 3, 2);

    // branch draining through S4 while halted
    halt_req = 1'b1;
    step("halt2_in", 0, 4'b0010, 1, 0, 8'h00, 0, 3, 2);
    branch(16'h0033);
    step("halt2_br", 1, 4'b0111, 0, 1, 8'h33, 1, 3, 2);
    clr_in(); halt_req = 1'b1;
    step("halt2_hold", 0, 4'b0010, 1, 0, 8'h00, 1, 3, 3);
    halt_req = 1'b0;
    step("halt2_rel", 0, 4'b0010, 1, 0, 8'h00, 1, 3, 3);
    step("halt2_exit", 1, 4'b0000, 0, 0, 8'h00, 0, 3, 3);

    // hazard outranks halt
    halt_req = 1'b1; ld2(3'd5); s1_reads(3'd5, 3'd0, 3'd0, 3'b100);
    step("haz_vs_halt", 0, 4'b0010, 1, 0, 8'h00, 0, 3, 3);
    clr_in(); halt_req = 1'b1;
    step("halt3_in", 0, 4'b0010, 1, 0, 8'h00, 0, 4, 3);
    halt_req = 1'b0;
    step("halt3_rel", 0, 4'b0010, 1, 0, 8'h00, 1, 4, 3);
    step("halt3_exit", 1, 4'b0000, 0, 0, 8'h00, 0, 4, 3);

    // drive stall counter into saturation
    clr_in(); ld2(3'd1); s1_reads(3'd1, 3'd0, 3'd0, 3'b100);
    for (int i = 0; i < 14; i++)
      step($sformatf("sat_%0d", i), 0, 4'b0010, 1, 0, 8'h00, 0,
           (4 + i > 15) ? 4'd15 : 4'(4 + i), 3);
    clr_in();
    step("sat_end", 1, 4'b0000, 0, 0, 8'h00, 0, 15, 3);

    // asynchronous reset in the middle of BRFLUSH
    branch(16'h0077);
    step("br3", 1, 4'b0111, 0, 1, 8'h77, 0, 15, 3);
    clr_in();
    #1;
    rst = 1'b0;
    #1;
    expect_out("mid_rst", 0, 4'b1111, 1, 0, 8'h00, 0, 0, 0);
    compare_out();
    @(posedge clk);
    #1;
    rst = 1'b1;
    step("rst_rel", 1, 4'b0000, 0, 0, 8'h00, 0, 0, 0);
    branch(16'h0005);
    step("rst_br", 1, 4'b0111, 0, 1, 8'h05, 0, 0, 0);
    clr_in();
    step("rst_brflush", 1, 4'b0001, 0, 0, 8'h00, 0, 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
